// File: rtl/front_panel_ctrl.sv
// Front-panel responder: synchronizes and debounces panel buttons/run switch and
// turns each press into one Load_PC / Deposit / Load_AC / Step command for the CPU.
module front_panel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ADDR_W          = 12
) (
    input  logic              clk,
    input  logic              btnCpuReset,
    input  logic              btnl,
    input  logic              btnd,
    input  logic              btnr,
    input  logic              btnu,
    input  logic [ADDR_W:0]   sw,
    input  logic              cpu_halted,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              pc_load,
    output logic              ac_load,
    output logic [ADDR_W-1:0] load_value,
    output logic              cpu_step,
    output logic              cpu_run,
    output logic [ADDR_W-1:0] panel_addr,
    output logic              busy
);
    localparam int NIN   = 5;
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOADPC, S_LOADAC, S_DEP_WR, S_DEP_INC, S_STEP
    } state_t;

    // Input bit order: 0 Load_PC, 1 Deposit, 2 Load_AC, 3 Step, 4 run switch
    logic [NIN-1:0]            raw;
    logic [NIN-1:0]            sync1_q, sync2_q, deb_q, deb_d;
    logic [NIN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]                rise_q, rise_d;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cap_q, cap_d;
    logic [ADDR_W-1:0] panel_q, panel_d;
    logic              run_q, run_d;
    logic              pc_load_q, pc_load_d;
    logic              ac_load_q, ac_load_d;
    logic              step_q, step_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;

    assign raw = {sw[ADDR_W], btnu, btnr, btnd, btnl};

    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1))
                    deb_d[i] = sync2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        rise_d = deb_d[3:0] & ~deb_q[3:0];
    end

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        panel_d = panel_q;
        case (state_q)
            S_IDLE: begin
                // Requests that are not accepted here are simply lost.
                if (!run_q) begin
                    if (rise_q[0]) begin
                        state_d = S_LOADPC;
                        cap_d   = sw[ADDR_W-1:0];
                        panel_d = sw[ADDR_W-1:0];
                    end else if (rise_q[1]) begin
                        state_d = S_DEP_WR;
                        cap_d   = sw[ADDR_W-1:0];
                    end else if (rise_q[2]) begin
                        state_d = S_LOADAC;
                        cap_d   = sw[ADDR_W-1:0];
                    end else if (rise_q[3] && cpu_halted) begin
                        state_d = S_STEP;
                    end
                end
            end
            S_DEP_WR:  if (mem_ack) state_d = S_DEP_INC;
            S_DEP_INC: begin
                panel_d = panel_q + ADDR_W'(1);
                state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase

        // Run may start only between commands but stops at once.
        run_d = run_q;
        if (!deb_q[4])
            run_d = 1'b0;
        else if (state_q == S_IDLE)
            run_d = 1'b1;

        pc_load_d = (state_d == S_LOADPC);
        ac_load_d = (state_d == S_LOADAC);
        step_d    = (state_d == S_STEP);
        we_d      = (state_d == S_DEP_WR);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            cnt_q     <= '0;
            rise_q    <= '0;
            state_q   <= S_IDLE;
            cap_q     <= '0;
            panel_q   <= '0;
            run_q     <= 1'b0;
            pc_load_q <= 1'b0;
            ac_load_q <= 1'b0;
            step_q    <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            rise_q    <= rise_d;
            state_q   <= state_d;
            cap_q     <= cap_d;
            panel_q   <= panel_d;
            run_q     <= run_d;
            pc_load_q <= pc_load_d;
            ac_load_q <= ac_load_d;
            step_q    <= step_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
        end
    end

    assign mem_addr   = panel_q;
    assign mem_wdata  = cap_q;
    assign mem_we     = we_q;
    assign pc_load    = pc_load_q;
    assign ac_load    = ac_load_q;
    assign load_value = cap_q;
    assign cpu_step   = step_q;
    assign cpu_run    = run_q;
    assign panel_addr = panel_q;
    assign busy       = busy_q;
endmodule
